// File: rtl/bram_ctrl_if.sv
// Request/response bus between a requester and the BRAM controller.
// The master drives requests and consumes read data; the slave is the controller.
interface bram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bram_ctrl.sv
// Single-port BRAM controller: registered issue stage, two-cycle read pipeline
// and a small response FIFO whose free space gates request acceptance.
module bram_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    bram_ctrl_if.slave  bus,
    output logic        bram_EN0,
    output logic [3:0]  bram_WE0,
    output logic [31:0] bram_A0,
    output logic [31:0] bram_Di0,
    input  logic [31:0] bram_Do0
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

    logic          r_ready;
    logic          r_en;
    logic [3:0]    r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_di;
    logic          r_rd_s1;
    logic          r_rd_s2;
    logic [1:0]    r_inflight;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_acc_read;
    logic          w_capture;
    logic          w_pop;
    logic [1:0]    w_inflight_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [CW:0]   w_occ_nxt;
    logic          w_unused_addr_lsbs;

    assign w_accept   = bus.req_valid && r_ready;
    assign w_acc_read = w_accept && (bus.req_we == 4'b0000);
    assign w_capture  = r_rd_s2;
    assign w_pop      = bus.rsp_valid && bus.rsp_ready;

    // Reads still in the pipeline reserve FIFO space, so a capture always finds a free slot.
    assign w_inflight_nxt = r_inflight + 2'(w_acc_read) - 2'(w_capture);
    assign w_count_nxt    = r_count + CW'(w_capture) - CW'(w_pop);
    assign w_occ_nxt      = (CW + 1)'(w_count_nxt) + (CW + 1)'(w_inflight_nxt);

    // Byte offset within the word has no effect on the access.
    assign w_unused_addr_lsbs = ^bus.req_addr[1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ready    <= 1'b0;
            r_en       <= 1'b0;
            r_we       <= '0;
            r_addr     <= '0;
            r_di       <= '0;
            r_rd_s1    <= 1'b0;
            r_rd_s2    <= 1'b0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_ready    <= w_occ_nxt < DEPTH_OCC;
            r_en       <= w_accept;
            r_we       <= w_accept ? bus.req_we : 4'b0000;
            if (w_accept) begin
                r_addr <= {2'b00, bus.req_addr[31:2]};
                r_di   <= bus.req_wdata;
            end
            r_rd_s1    <= w_acc_read;
            r_rd_s2    <= r_rd_s1;
            r_inflight <= w_inflight_nxt;
            r_count    <= w_count_nxt;
            if (w_capture)
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
        end
    end

    // NOTE: FIFO storage has no reset; an empty FIFO masks the head to zero,
    // so stale words are never visible.
    always_ff @(posedge CLK) begin
        if (w_capture)
            r_mem[r_wr_ptr] <= bram_Do0;
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = (r_count != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? r_mem[r_rd_ptr] : '0;

    assign bram_EN0 = r_en;
    assign bram_WE0 = r_we;
    assign bram_A0  = r_addr;
    assign bram_Di0 = r_di;
endmodule

// File: tb/tb_bram_ctrl.sv
// Self-checking bench for bram_ctrl: table of single transactions, then
// back-pressure, streaming, mid-flight reset and read/write ordering sequences.
module tb_bram_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic        bram_EN0;
    logic [3:0]  bram_WE0;
    logic [31:0] bram_A0;
    logic [31:0] bram_Di0;
    logic [31:0] bram_Do0;
    logic [31:0] ram [256];

    int checks = 0;
    int errors = 0;

    bram_ctrl_if bus ();

    bram_ctrl #(.DEPTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .bram_EN0 (bram_EN0),
        .bram_WE0 (bram_WE0),
        .bram_A0  (bram_A0),
        .bram_Di0 (bram_Di0),
        .bram_Do0 (bram_Do0)
    );

    always #5 CLK = ~CLK;

    // Read-first synchronous BRAM with byte write enables.
    always @(posedge CLK) begin
        if (bram_EN0) begin
            bram_Do0 <= ram[bram_A0[7:0]];
            for (int b = 0; b < 4; b++)
                if (bram_WE0[b]) ram[bram_A0[7:0]][8*b +: 8] = bram_Di0[8*b +: 8];
        end
    end

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_a0;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_vec(input int k, input vec_t v);
        int n;
        @(negedge CLK);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("v%0d_ready", k), 32'(bus.req_ready), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check($sformatf("v%0d_en", k), 32'(bram_EN0), 32'd1);
        check($sformatf("v%0d_we", k), 32'(bram_WE0), 32'(v.we));
        check($sformatf("v%0d_a0", k), bram_A0, v.exp_a0);
        check($sformatf("v%0d_di", k), bram_Di0, v.wdata);
        check($sformatf("v%0d_rsp_early", k), 32'(bus.rsp_valid), 32'd0);
        @(negedge CLK);
        check($sformatf("v%0d_en_idle", k), 32'(bram_EN0), 32'd0);
        check($sformatf("v%0d_we_idle", k), 32'(bram_WE0), 32'd0);
        check($sformatf("v%0d_a0_hold", k), bram_A0, v.exp_a0);
        check($sformatf("v%0d_rsp_e1", k), 32'(bus.rsp_valid), 32'd0);
        @(negedge CLK);
        if (v.we == 4'b0000) begin
            check($sformatf("v%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("v%0d_rdata", k), bus.rsp_rdata, v.exp_rdata);
            @(negedge CLK);
            check($sformatf("v%0d_rsp_popped", k), 32'(bus.rsp_valid), 32'd0);
        end else begin
            check($sformatf("v%0d_no_rsp", k), 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    // Back-to-back reads of words base..base+n-1; rsp_ready held low for the first 'stall' cycles.
    task automatic stream(input string tag, input int base, input int n, input int stall,
                          input logic [31:0] off, input logic [31:0] step);
        int idx = 0, got = 0, cyc = 0;
        int first_v = -1, last_v = -1, vcount = 0, last_acc = -1;
        logic will_acc;
        while (got < n && cyc < 200) begin
            @(negedge CLK);
            bus.rsp_ready = (cyc >= stall);
            bus.req_valid = (idx < n);
            bus.req_we    = 4'b0000;
            bus.req_addr  = 32'((base + idx) * 4);
            bus.req_wdata = '0;
            if (stall > 0 && cyc == stall) begin
                check({tag, "_accepted_at_stall"}, 32'(idx), 32'd4);
                check({tag, "_ready_full"}, 32'(bus.req_ready), 32'd0);
                check({tag, "_head_held"}, bus.rsp_rdata, off);
            end
            if (bus.rsp_valid) begin
                vcount++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            will_acc = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid && bus.rsp_ready) begin
                check($sformatf("%s_rdata%0d", tag, got), bus.rsp_rdata, off + step * 32'(got));
                got++;
            end
            @(posedge CLK);
            if (will_acc) begin
                idx++;
                last_acc = cyc;
            end
            cyc++;
        end
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check({tag, "_responses"}, 32'(got), 32'(n));
        check({tag, "_accepts"}, 32'(idx), 32'(n));
        if (stall == 0) begin
            check({tag, "_first_rsp_cycle"}, 32'(first_v), 32'd3);
            check({tag, "_last_accept_cycle"}, 32'(last_acc), 32'(n - 1));
            check({tag, "_valid_cycles"}, 32'(vcount), 32'(n));
            check({tag, "_valid_span"}, 32'(last_v - first_v), 32'(n - 1));
        end
    endtask

    initial begin
        int seen_v, seen_we, got, k, cyc;
        logic will_acc;
        logic [31:0] hz_exp [2];

        for (int i = 0; i < 256; i++) ram[i] = '0;
        RST           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        vecs[0] = '{4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0004, 32'h0};
        vecs[1] = '{4'h0,    32'h0000_0010, 32'h0,         32'h0000_0004, 32'hDEAD_BEEF};
        vecs[2] = '{4'hF,    32'h0000_0020, 32'h1122_3344, 32'h0000_0008, 32'h0};
        vecs[3] = '{4'b0010, 32'h0000_0020, 32'h0000_AA00, 32'h0000_0008, 32'h0};
        vecs[4] = '{4'h0,    32'h0000_0020, 32'h0,         32'h0000_0008, 32'h1122_AA44};
        vecs[5] = '{4'h0,    32'h0000_0013, 32'h0,         32'h0000_0004, 32'hDEAD_BEEF};
        vecs[6] = '{4'b1001, 32'h0000_007C, 32'hCAFE_F00D, 32'h0000_001F, 32'h0};
        vecs[7] = '{4'h0,    32'h0000_007E, 32'h0,         32'h0000_001F, 32'hCA00_000D};
        vecs[8] = '{4'hF,    32'hFFFF_FFF0, 32'h5A5A_5A5A, 32'h3FFF_FFFC, 32'h0};
        vecs[9] = '{4'h0,    32'hFFFF_FFF0, 32'h0,         32'h3FFF_FFFC, 32'h5A5A_5A5A};

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_en", 32'(bram_EN0), 32'd0);
        check("rst_we", 32'(bram_WE0), 32'd0);
        check("rst_a0", bram_A0, 32'd0);
        check("rst_di", bram_Di0, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 10; i++) do_vec(i, vecs[i]);

        // Back-pressure: only four reads fit, the rest follow once responses drain.
        for (int i = 0; i < 6; i++) ram[32 + i] = 32'h100 + 32'(i);
        stream("bp", 32, 6, 10, 32'h100, 32'd1);

        // Full-rate streaming across several pointer wraps.
        for (int i = 0; i < 16; i++) ram[i] = 32'(i * 3);
        stream("tp", 0, 16, 0, 32'd0, 32'd3);

        // Reset while two reads are in flight.
        @(negedge CLK);
        bus.rsp_ready = 1'b1;
        bus.req_we    = 4'b0000;
        bus.req_addr  = 32'h0;
        bus.req_valid = 1'b1;
        check("rr_ready0", 32'(bus.req_ready), 32'd1);
        @(negedge CLK);
        check("rr_ready1", 32'(bus.req_ready), 32'd1);
        bus.req_addr = 32'h4;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("rr_en_async", 32'(bram_EN0), 32'd0);
        check("rr_rsp_async", 32'(bus.rsp_valid), 32'd0);
        repeat (2) begin
            @(negedge CLK);
            check("rr_en_in_rst", 32'(bram_EN0), 32'd0);
            check("rr_ready_in_rst", 32'(bus.req_ready), 32'd0);
        end
        RST = 1'b0;
        seen_v  = 0;
        seen_we = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 0) check("rr_ready_after", 32'(bus.req_ready), 32'd1);
            if (bus.rsp_valid) seen_v++;
            if (bram_WE0 != 4'b0000) seen_we++;
        end
        check("rr_no_rsp", 32'(seen_v), 32'd0);
        check("rr_no_we", 32'(seen_we), 32'd0);

        // Read, write, read of one word: old value first, then the new one.
        ram[16]  = 32'h77;
        hz_exp[0] = 32'h77;
        hz_exp[1] = 32'h5;
        k   = 0;
        got = 0;
        cyc = 0;
        while (got < 2 && cyc < 30) begin
            @(negedge CLK);
            bus.rsp_ready = 1'b1;
            bus.req_valid = (k < 3);
            bus.req_addr  = 32'h40;
            bus.req_we    = (k == 1) ? 4'hF : 4'h0;
            bus.req_wdata = (k == 1) ? 32'h5 : 32'h0;
            will_acc = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid) begin
                check($sformatf("hz_rdata%0d", got), bus.rsp_rdata, hz_exp[got]);
                got++;
            end
            @(posedge CLK);
            if (will_acc) k++;
            cyc++;
        end
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check("hz_responses", 32'(got), 32'd2);
        check("hz_accepts", 32'(k), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_ctrl.md
BRAM_CTRL -- requirements
Module: bram_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, response FIFO depth in words; fixed at 4 for this release.
REQ-002 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-003 Port: RST  in  1  reset, asynchronous assert, active-high.
REQ-004 Port: req_valid  in  1  request present.
REQ-005 Port: req_ready  out  1  controller accepts the request this cycle.
REQ-006 Port: req_we  in  4  byte write strobes; 4'b0000 means read.
REQ-007 Port: req_addr  in  32  byte address.
REQ-008 Port: req_wdata  in  32  write data.
REQ-009 Port: rsp_valid  out  1  read data available.
REQ-010 Port: rsp_ready  in  1  consumer takes read data.
REQ-011 Port: rsp_rdata  out  32  read data.
REQ-012 Port: bram_EN0, bram_WE0, bram_A0, bram_Di0  out  1/4/32/32  registered drive of the BRAM port (EN0, WE0, A0, Di0).
REQ-013 Port: bram_Do0  in  32  BRAM read data; valid the cycle after the EN0 edge.

Function
REQ-014 Request accepted at a rising edge where req_valid && req_ready.
REQ-015 req_ready = (fifo_count + inflight_reads) < DEPTH; it is independent of req_valid, req_we, req_addr, and req_wdata.
REQ-016 Issue stage is registered. After the accept edge: bram_EN0=1, bram_WE0=req_we, bram_A0={2'b00,req_addr[31:2]}, bram_Di0=req_wdata, all held for exactly one cycle.
REQ-017 Cycles without acceptance: bram_EN0=0 and bram_WE0=0. bram_A0 and bram_Di0 hold their last values.
REQ-018 req_addr[1:0] is ignored; there is no error or misalignment response.
REQ-019 Writes (req_we != 0) produce no response and do not consume FIFO space.
REQ-020 Read timing: accept at edge E0, BRAM samples at E1, bram_Do0 is captured into the FIFO at E2, and rsp_valid is high after E2 when the FIFO was empty. Minimum latency is 2 cycles.
REQ-021 inflight_reads counts reads accepted but not yet captured, range 0..2. It increments at accept and decrements at capture; both in the same cycle leaves it unchanged.
REQ-022 FIFO ordering: responses leave in acceptance order. rsp_rdata = FIFO head. rsp_rdata and rsp_valid stay stable while rsp_valid && !rsp_ready.
REQ-023 Pop occurs at an edge where rsp_valid && rsp_ready. Capture and pop at the same edge leave fifo_count unchanged and keep data correct, including when the FIFO holds exactly one entry.
REQ-024 The FIFO can never overflow, by REQ-015. An implementation reaching a capture while fifo_count==DEPTH is nonconforming.
REQ-025 Hazard order: a read accepted the cycle after a write to the same word returns the new data. A read and write are never issued in the same cycle; the port is single.
REQ-026 Throughput: with rsp_ready held at 1, one request is accepted every cycle indefinitely, mixed reads and writes.
REQ-027 Pointer wrap: FIFO read and write pointers wrap modulo DEPTH, with no bubble at wrap.

Reset
REQ-028 While RST=1: req_ready=0, rsp_valid=0, rsp_rdata=0, bram_EN0=0, bram_WE0=0, bram_A0=0, bram_Di0=0, fifo_count=0, inflight_reads=0.
REQ-029 RST asserted mid-operation discards all in-flight reads and FIFO contents. The first edge after RST deassert makes req_ready=1.
REQ-030 BRAM contents are not touched by reset; no write strobe is emitted during or after reset without a request.

Verification
REQ-031 Scenario: write 0xDEADBEEF to addr 0x10 with we=4'hF, then read 0x10 -> bram_A0=0x4 on both, and rsp_rdata=0xDEADBEEF 2 cycles after the read accept.
REQ-032 Scenario: write 0x11223344 to 0x20 with we=4'hF, then we=4'b0010 with data 0x0000AA00, then read 0x20 -> rsp_rdata=0x1122AA44.
REQ-033 Scenario: rsp_ready=0 and 6 back-to-back reads -> exactly 4 accepted, req_ready=0 thereafter. Release rsp_ready -> 4 responses in order, then the remaining 2 are accepted.
REQ-034 Scenario: rsp_ready=1 and 16 back-to-back reads of words 0..15 preloaded with values i*3 -> 16 consecutive rsp_valid cycles with data 0,3,...,45, and FIFO pointers wrap 4 times.
REQ-035 Scenario: 2 reads accepted, RST pulsed while both are in flight -> no rsp_valid ever appears for them, and bram_EN0=0 during RST.
REQ-036 Scenario: read at 0x40, write 0x5 to 0x40 the next cycle, read 0x40 again -> responses are the old value then 0x5, confirming read-first and in-order.
